// File: rtl/demux4to16_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux4to16_frame: steers 4-lane beats into four slots, emits 16-lane frame |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module demux4to16_frame #(
  parameter int LANE_W = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            selector,
  input  logic [4*LANE_W-1:0]   y_in,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [16*LANE_W-1:0]  frame_data,
  output logic [3:0]            slot_mask,
  output logic                  overwrite_err
);

  localparam int SLOT_W = 4 * LANE_W;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [16*LANE_W-1:0]  r_data;
  logic [3:0]            r_mask;
  logic [1:0]            r_cnt;
  logic                  r_mode;
  logic                  r_ovf;

  logic                  w_accept;
  logic                  w_handoff;
  logic                  w_mode_eff;
  logic [1:0]            w_target;
  logic [3:0]            w_mask_set;

  // The mode pin only matters on the first beat of a frame; afterwards the latched copy rules.
  assign w_mode_eff = (r_mask == 4'h0) ? mode : r_mode;
  assign w_target   = w_mode_eff ? selector : r_cnt;
  assign w_mask_set = r_mask | (4'b0001 << w_target);
  assign w_accept   = in_valid & in_ready;
  assign w_handoff  = frame_valid & frame_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: if (w_accept && (w_mask_set == 4'hF)) w_state_nxt = S_HOLD;
      S_HOLD: if (frame_ready) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == S_FILL);
    frame_valid = (r_state == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_mask <= 4'h0;
      r_cnt  <= 2'd0;
      r_mode <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (w_accept) begin
        for (int k = 0; k < 4; k++) begin
          if (w_target == k[1:0]) r_data[k*SLOT_W +: SLOT_W] <= y_in;
        end
        r_mask <= w_mask_set;
        r_ovf  <= w_mode_eff & r_mask[w_target];
        if (r_mask == 4'h0) r_mode <= mode;
        if (!w_mode_eff) r_cnt <= r_cnt + 2'd1;
      end else if (w_handoff) begin
        // Data is left in place; the next frame overwrites it slot by slot.
        r_mask <= 4'h0;
        r_cnt  <= 2'd0;
      end
    end
  end

  assign frame_data    = r_data;
  assign slot_mask     = r_mask;
  assign overwrite_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_demux4to16_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_demux4to16_frame: directed stimulus, frame scoreboard and status checks |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_demux4to16_frame;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  selector;
  logic [3:0]  y_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_data;
  logic [3:0]  slot_mask;
  logic        overwrite_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];

  demux4to16_frame #(.LANE_W(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .mode          (mode),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .selector      (selector),
    .y_in          (y_in),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .frame_data    (frame_data),
    .slot_mask     (slot_mask),
    .overwrite_err (overwrite_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic status(input string nm, input logic [3:0] m, input logic v,
                        input logic r, input logic e);
    check({nm, "_mask"},  32'(slot_mask),     32'(m));
    check({nm, "_valid"}, 32'(frame_valid),   32'(v));
    check({nm, "_ready"}, 32'(in_ready),      32'(r));
    check({nm, "_ovf"},   32'(overwrite_err), 32'(e));
  endtask

  task automatic beat(input logic m, input logic [1:0] sel, input logic [3:0] y);
    mode     = m;
    selector = sel;
    y_in     = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic handoff();
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; in_valid = 1'b0; selector = 2'd0;
    y_in = 4'h0; frame_ready = 1'b0;

    // Monitor: compares each frame at the handshake against the scoreboard head.
    fork
      forever begin
        @(negedge clk);
        if (frame_valid && frame_ready) begin
          check("frame_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("frame_data_out", 32'(frame_data), 32'(exp_q.pop_front()));
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    status("reset", 4'h0, 1'b0, 1'b1, 1'b0);
    check("reset_data", 32'(frame_data), 32'h0);
    reset = 1'b0;

    // Auto fill
    beat(1'b0, 2'd0, 4'h1); check("auto1_mask", 32'(slot_mask), 32'h1);
    beat(1'b0, 2'd0, 4'h2); check("auto2_mask", 32'(slot_mask), 32'h3);
    beat(1'b0, 2'd0, 4'h4); check("auto3_mask", 32'(slot_mask), 32'h7);
    exp_q.push_back(16'h8421);
    beat(1'b0, 2'd0, 4'h8);
    status("auto4", 4'hF, 1'b1, 1'b0, 1'b0);
    check("auto4_data", 32'(frame_data), 32'h8421);

    // Backpressure: beats offered while holding must be ignored
    in_valid = 1'b1; y_in = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_data", 32'(frame_data), 32'h8421);
    end
    check("bp_valid", 32'(frame_valid), 32'h1);
    in_valid = 1'b0;
    handoff();
    status("bp_after", 4'h0, 1'b0, 1'b1, 1'b0);

    // Tagged out-of-order
    beat(1'b1, 2'd3, 4'hA);
    beat(1'b1, 2'd0, 4'h5);
    beat(1'b1, 2'd2, 4'hC);
    check("tag3_mask", 32'(slot_mask), 32'hD);
    exp_q.push_back(16'hAC35);
    beat(1'b1, 2'd1, 4'h3);
    status("tag4", 4'hF, 1'b1, 1'b0, 1'b0);
    check("tag4_data", 32'(frame_data), 32'hAC35);
    handoff();
    check("tag_after_valid", 32'(frame_valid), 32'h0);

    // Tagged overwrite; untouched slots still show the previous frame
    beat(1'b1, 2'd2, 4'h1);
    status("ow1", 4'h4, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 2'd2, 4'h7);
    status("ow2", 4'h4, 1'b0, 1'b1, 1'b1);
    check("ow2_data", 32'(frame_data), 32'hA735);
    @(posedge clk);
    #1;
    check("ow_pulse_end", 32'(overwrite_err), 32'h0);

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    status("rst1", 4'h0, 1'b0, 1'b1, 1'b0);
    check("rst1_data", 32'(frame_data), 32'h0);

    // Mid-frame mode change is ignored
    beat(1'b0, 2'd3, 4'h1);
    beat(1'b0, 2'd3, 4'h2);
    beat(1'b1, 2'd0, 4'h4);
    status("mid", 4'h7, 1'b0, 1'b1, 1'b0);
    check("mid_data", 32'(frame_data), 32'h0421);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    status("rst2", 4'h0, 1'b0, 1'b1, 1'b0);
    check("rst2_data", 32'(frame_data), 32'h0);

    // Next frame starts at slot 0; frame_ready held high while filling has no effect
    frame_ready = 1'b1;
    beat(1'b0, 2'd3, 4'h9);
    check("post_mask", 32'(slot_mask), 32'h1);
    check("post_data", 32'(frame_data), 32'h0009);
    beat(1'b0, 2'd0, 4'h1);
    beat(1'b0, 2'd0, 4'h2);
    exp_q.push_back(16'h3219);
    beat(1'b0, 2'd0, 4'h3);
    status("post4", 4'hF, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    status("post_after", 4'h0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    check("frames_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux4to16_frame.md
Name: demux4to16_frame

Overview:
- Receive-side counterpart of the team's 4-lane 4:1 slot multiplexer. The multiplexer picks one of four slots (a,b,c,d lanes per slot) onto four lanes (y0..y3).
- This block accepts a stream of 4-lane beats and steers each beat into one of four slot registers. Slots are chosen by a wrapping slot counter (auto mode) or by an explicit 2-bit selector tag (tagged mode).
- Once all four slots are filled, it presents the rebuilt 16-lane frame under a valid/ready handshake.
- It sits between the lane link and the consumer of the full 16-lane word.

Parameters:
- LANE_W, 1, width in bits of each lane (a,b,c,d and y).

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = auto slot counter, 1 = tagged (slot taken from selector); sampled only on the first accept of a frame.
- in_valid  input  1  beat on y_in/selector is valid.
- in_ready  output  1  block can accept a beat this cycle.
- selector  input  2  slot tag, used in tagged mode only.
- y_in  input  4*LANE_W  beat lanes; lane0 → a, lane1 → b, lane2 → c, lane3 → d of the target slot.
- frame_valid  output  1  frame_data holds a complete frame.
- frame_ready  input  1  consumer accepts the frame.
- frame_data  output  16*LANE_W  slot k occupies bits [4*LANE_W*(k+1)-1 : 4*LANE_W*k], lane order within a slot: a (lsb), b, c, d.
- slot_mask  output  4  bit k set when slot k has been written in the current frame.
- overwrite_err  output  1  one-cycle pulse when a tagged beat hits an already-filled slot.

Behaviour:
- Reset values:
  - state = FILL; in_ready = 1; frame_valid = 0.
  - frame_data = 0; slot_mask = 0; overwrite_err = 0.
  - Slot counter = 0; latched mode = 0.
- Accept: a beat is accepted on a rising edge with in_valid & in_ready.
- FILL state, in_ready = 1. On accept:
  - Target slot is the counter in auto mode, or selector in tagged mode.
  - y_in is written into the target slot of frame_data, and slot_mask[target] is set.
  - In auto mode the counter increments, wrapping 3 → 0.
- Mode latch: when slot_mask == 0, mode is latched on the accept. A mode change mid-frame is ignored until the next frame.
- Tagged duplicate: a beat to an already-set slot overwrites the data, leaves the mask unchanged and pulses overwrite_err for one cycle (the cycle after the accept).
- FILL → HOLD: when the accept makes slot_mask == 4'hF. frame_valid goes 1 in the next cycle, so there is 1 cycle of latency from the 4th accept.
- HOLD state:
  - in_ready = 0; frame_data and slot_mask are frozen while frame_valid = 1, independent of in_valid.
  - On frame_valid & frame_ready: next cycle frame_valid = 0, slot_mask = 0, counter = 0, state = FILL, in_ready = 1.
  - frame_data keeps its old contents until overwritten slot by slot.
- No same-cycle frame handoff plus new accept; there is a minimum one-cycle bubble.
- frame_ready while frame_valid = 0 has no effect.
- reset has priority over every event, including mid-frame and mid-HOLD. It discards the partial or held frame and restores all reset values on the next edge.
- Outputs are registered. in_ready is a pure function of state.
- Tagged mode with missing slots: the frame never completes until every slot is written; there is no timeout.

Test Plan:
- Auto fill: reset, mode = 0, LANE_W = 1, beats y_in = 4'h1, 4'h2, 4'h4, 4'h8 on consecutive cycles → slot_mask 1, 3, 7, F; frame_valid = 1 one cycle after 4th accept; frame_data = 16'h8421; in_ready = 0.
- Backpressure: hold frame_ready = 0 for 5 cycles with in_valid = 1, y_in = 4'hF → frame_data stays 16'h8421, no accepts. Then frame_ready = 1 for one cycle → next cycle frame_valid = 0, slot_mask = 0, in_ready = 1.
- Tagged out-of-order: mode = 1, selector 3, 0, 2, 1 with y_in = 4'hA, 4'h5, 4'hC, 4'h3 → frame_data = 16'hAC35, frame_valid after 4th accept.
- Tagged overwrite: mode = 1, selector 2 with y_in = 4'h1, then selector 2 with y_in = 4'h7 → overwrite_err pulses once, slot_mask = 4'b0100, slot2 = 4'h7.
- Mid-frame mode change and reset: mode = 0, two accepts, then mode = 1 with selector = 0 → beat goes to slot 2 (auto mode persists). Then assert reset → next cycle all outputs at reset values, and the following frame starts from slot 0.
